mul_pipeline_param: RTL and testbench

Parametrised, iterative, multi-cycle integer multiplier; successor to the fixed 32-bit clocked multiplier.
Generalised in operand width and in bits retired per cycle (radix).
Supports the four RISC-V M-extension multiply variants: MUL, MULH, MULHSU, MULHU.
Sits behind the ALU issue logic with a req/ack handshake; the core stalls on busy.

---
 rtl/mul_pipeline_param.sv | 134 +++++++++++++
 tb/tb_mul_pipeline_param.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_pipeline_param.sv
// Iterative shift-add multiplier for MUL/MULH/MULHSU/MULHU with configurable
// operand width and multiplier bits retired per cycle; req/ack handshake.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | waiting for req; out holds the last result
// S_CALC | one multiplier digit accumulated per edge, N edges in total
// S_FIX  | apply the result sign, select the low/high half into out
// S_DONE | ack cycle; a new req is accepted here back-to-back
module mul_pipeline_param #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             ack,
    output logic [WIDTH-1:0] out
);

    localparam int N     = WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam int BPC   = BITS_PER_CYCLE;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic               accept;
    logic               iter_last;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_abs, b_abs;

    logic [1:0]         op_q;
    logic               neg_q;
    logic [WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [CNT_W-1:0]   iter_q;
    logic [2*WIDTH-1:0] acc_q;

    logic [WIDTH+BPC-1:0]   partial;
    logic [WIDTH+BPC-1:0]   acc_sum;
    logic [2*WIDTH+BPC-1:0] acc_wide;
    logic [2*WIDTH-1:0]     acc_step;
    logic [2*WIDTH-1:0]     product;

    assign accept    = req && ((state == S_IDLE) || (state == S_DONE));
    assign iter_last = (iter_q == '0);

    // Operand magnitudes: a is signed for MULH/MULHSU, b only for MULH.
    always_comb begin
        a_neg = ((op == OP_MULH) || (op == OP_MULHSU)) && a[WIDTH-1];
        b_neg = (op == OP_MULH) && b[WIDTH-1];
        a_abs = a_neg ? (-a) : a;
        b_abs = b_neg ? (-b) : b;
    end

    // Right-shifting accumulator: each step adds one digit's partial product
    // into the upper half, then shifts the whole register down by BPC bits.
    always_comb begin
        partial  = {{BPC{1'b0}}, mcand_q} * {{WIDTH{1'b0}}, mplier_q[BPC-1:0]};
        acc_sum  = {{BPC{1'b0}}, acc_q[2*WIDTH-1:WIDTH]} + partial;
        acc_wide = {acc_sum, acc_q[WIDTH-1:0]};
        acc_step = acc_wide[2*WIDTH+BPC-1:BPC];
        product  = neg_q ? (-acc_q) : acc_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (req) state_nxt = S_CALC;
            S_CALC: if (iter_last) state_nxt = S_FIX;
            S_FIX:  state_nxt = S_DONE;
            S_DONE: state_nxt = req ? S_CALC : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign busy = (state == S_CALC) || (state == S_FIX);
    assign ack  = (state == S_DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q     <= 2'b00;
            neg_q    <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            iter_q   <= '0;
            acc_q    <= '0;
            out      <= '0;
        end else begin
            if (accept) begin
                op_q     <= op;
                neg_q    <= a_neg ^ b_neg;
                mcand_q  <= a_abs;
                mplier_q <= b_abs;
                iter_q   <= CNT_LAST;
                acc_q    <= '0;
            end else if (state == S_CALC) begin
                acc_q    <= acc_step;
                mplier_q <= mplier_q >> BPC;
                iter_q   <= iter_q - CNT_ONE;
            end
            if (state == S_FIX) begin
                out <= (op_q == OP_MUL) ? product[WIDTH-1:0] : product[2*WIDTH-1:WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_mul_pipeline_param.sv
// Bench for mul_pipeline_param: three instances (32/1, 32/4, 8/2) checked every
// cycle against a transaction-level model, plus directed literal vectors.
module tb_mul_pipeline_param;

    localparam int NN[3] = '{32, 8, 4};
    localparam int WW[3] = '{32, 32, 8};

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  req_v = 3'b000;
    logic [1:0]  op_v [3] = '{2'b00, 2'b00, 2'b00};
    logic [31:0] a_v  [3] = '{32'h0, 32'h0, 32'h0};
    logic [31:0] b_v  [3] = '{32'h0, 32'h0, 32'h0};

    logic        busy0, busy1, busy2;
    logic        ack0, ack1, ack2;
    logic [31:0] out0, out1;
    logic [7:0]  out2;

    int n_cmp = 0;
    int n_bad = 0;

    int          m_cnt  [3] = '{0, 0, 0};
    logic        m_ack  [3] = '{1'b0, 1'b0, 1'b0};
    logic [31:0] m_out  [3] = '{32'h0, 32'h0, 32'h0};
    logic [31:0] m_pend [3] = '{32'h0, 32'h0, 32'h0};

    always #5 clk = ~clk;

    mul_pipeline_param #(.WIDTH(32), .BITS_PER_CYCLE(1)) u_dut0 (
        .clk(clk), .rst(rst), .req(req_v[0]), .op(op_v[0]), .a(a_v[0]), .b(b_v[0]),
        .busy(busy0), .ack(ack0), .out(out0));

    mul_pipeline_param #(.WIDTH(32), .BITS_PER_CYCLE(4)) u_dut1 (
        .clk(clk), .rst(rst), .req(req_v[1]), .op(op_v[1]), .a(a_v[1]), .b(b_v[1]),
        .busy(busy1), .ack(ack1), .out(out1));

    mul_pipeline_param #(.WIDTH(8), .BITS_PER_CYCLE(2)) u_dut2 (
        .clk(clk), .rst(rst), .req(req_v[2]), .op(op_v[2]), .a(a_v[2][7:0]), .b(b_v[2][7:0]),
        .busy(busy2), .ack(ack2), .out(out2));

    // Exact product of the operands interpreted per op, then the selected half.
    function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input int w);
        logic [31:0]         mask;
        longint              ai, bi;
        logic signed [129:0] pa, pb, p;
        logic [129:0]        sh;
        mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        ai = longint'(a & mask);
        bi = longint'(b & mask);
        if ((op == 2'b01 || op == 2'b10) && a[w-1]) ai = ai - (longint'(1) << w);
        if (op == 2'b01 && b[w-1]) bi = bi - (longint'(1) << w);
        pa = ai;
        pb = bi;
        p  = pa * pb;
        sh = (op == 2'b00) ? p : (p >> w);
        return sh[31:0] & mask;
    endfunction

    function automatic logic [31:0] dut_out(input int i);
        case (i)
            0:       return out0;
            1:       return out1;
            default: return {24'h0, out2};
        endcase
    endfunction

    function automatic logic dut_ack(input int i);
        case (i)
            0:       return ack0;
            1:       return ack1;
            default: return ack2;
        endcase
    endfunction

    function automatic logic dut_busy(input int i);
        case (i)
            0:       return busy0;
            1:       return busy1;
            default: return busy2;
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: a request seen while idle completes exactly N+1 edges later.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                m_cnt[i] <= 0;
                m_ack[i] <= 1'b0;
                m_out[i] <= 32'h0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                m_ack[i] <= 1'b0;
                if (m_cnt[i] == 0) begin
                    if (req_v[i]) begin
                        m_cnt[i]  <= NN[i] + 1;
                        m_pend[i] <= ref_mul(op_v[i], a_v[i], b_v[i], WW[i]);
                    end
                end else begin
                    m_cnt[i] <= m_cnt[i] - 1;
                    if (m_cnt[i] == 1) begin
                        m_ack[i] <= 1'b1;
                        m_out[i] <= m_pend[i];
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            check($sformatf("cycle_dut%0d{busy,ack,out}", i),
                  {30'h0, dut_busy(i), dut_ack(i), dut_out(i)},
                  {30'h0, (m_cnt[i] != 0), m_ack[i], m_out[i]});
        end
    end

    // Drive a request, let it be taken at the next edge, then scramble inputs.
    task automatic issue(input int i, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        req_v[i] = 1'b1;
        op_v[i]  = op;
        a_v[i]   = a;
        b_v[i]   = b;
        @(posedge clk);
        #1;
        req_v[i] = 1'b0;
        op_v[i]  = 2'($urandom_range(0, 3));
        a_v[i]   = $urandom;
        b_v[i]   = $urandom;
        check($sformatf("accept_dut%0d{busy,ack}", i), {62'h0, dut_busy(i), dut_ack(i)}, 64'h2);
    endtask

    task automatic wait_ack(input int i, input logic [31:0] exp, input string name, input int k0);
        int k;
        k = k0;
        do begin
            @(posedge clk);
            #1;
            k++;
        end while (!dut_ack(i) && k < k0 + 300);
        check({name, "_latency"}, 64'(k), 64'(NN[i] + 1));
        check({name, "_out"}, {32'h0, dut_out(i)}, {32'h0, exp});
    endtask

    logic [31:0] ra, rb, rexp;
    logic [1:0]  rop;

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h8000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h0;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        check("model_mulhu_ones",  {32'h0, ref_mul(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32)}, 64'hFFFF_FFFE);
        check("model_mulhsu_ones", {32'h0, ref_mul(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32)}, 64'hFFFF_FFFF);
        check("model_mulh_w8",     {32'h0, ref_mul(2'b01, 32'h80, 32'h7F, 8)}, 64'hC0);

        repeat (3) @(posedge clk);
        #1;
        check("reset_dut0", {30'h0, busy0, ack0, out0}, 64'h0);
        check("reset_dut1", {30'h0, busy1, ack1, out1}, 64'h0);
        check("reset_dut2", {54'h0, busy2, ack2, out2}, 64'h0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        issue(0, 2'b00, 32'd3, 32'd5);
        wait_ack(0, 32'd15, "mul_3x5", 0);
        @(posedge clk);
        #1;
        check("ack_drops", {62'h0, busy0, ack0}, 64'h0);
        issue(0, 2'b00, 32'd15, 32'd0);
        wait_ack(0, 32'd0, "mul_15x0", 0);
        issue(0, 2'b00, 32'd127, 32'd31);
        wait_ack(0, 32'd3937, "mul_127x31", 0);
        issue(0, 2'b00, 32'd347911, 32'd12345);
        wait_ack(0, 32'd4294961295, "mul_347911x12345", 0);
        issue(0, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_ack(0, 32'hFFFF_FFFE, "mulhu_ones", 0);
        issue(0, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_ack(0, 32'h0, "mulh_ones", 0);
        issue(0, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_ack(0, 32'h1, "mul_ones", 0);
        issue(0, 2'b01, 32'h8000_0000, 32'h8000_0000);
        wait_ack(0, 32'h4000_0000, "mulh_minneg", 0);
        issue(0, 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_ack(0, 32'hFFFF_FFFF, "mulhsu_ones", 0);

        issue(0, 2'b00, 32'd3, 32'd5);
        req_v[0] = 1'b1;
        a_v[0]   = 32'd99;
        b_v[0]   = 32'd77;
        repeat (10) @(posedge clk);
        #1;
        req_v[0] = 1'b0;
        wait_ack(0, 32'd15, "req_ignored", 10);
        issue(0, 2'b00, 32'd6, 32'd7);
        wait_ack(0, 32'd42, "back_to_back", 0);

        issue(0, 2'b00, 32'd1000, 32'd1000);
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("async_reset", {30'h0, busy0, ack0, out0}, 64'h0);
        repeat (3) begin
            @(posedge clk);
            #1;
            check("no_ack_in_reset", {63'h0, ack0}, 64'h0);
        end
        @(negedge clk);
        rst = 1'b1;
        issue(0, 2'b00, 32'd150, 32'd40);
        wait_ack(0, 32'd6000, "after_reset", 0);

        issue(1, 2'b00, 32'd1254424, 32'd124);
        wait_ack(1, 32'd155548576, "bpc4_mul", 0);
        for (int n = 0; n < 200; n++) begin
            rop  = 2'($urandom_range(0, 1));
            ra   = pick();
            rb   = pick();
            rexp = ref_mul(rop, ra, rb, 32);
            issue(1, rop, ra, rb);
            wait_ack(1, rexp, "bpc4_random", 0);
        end

        issue(2, 2'b01, 32'h80, 32'h7F);
        wait_ack(2, 32'hC0, "w8_mulh", 0);
        issue(2, 2'b00, 32'h80, 32'h7F);
        wait_ack(2, 32'h80, "w8_mul", 0);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
